ref_clock_gen: RTL and testbench
================================

REF_CLOCK_GEN -- requirements
Module: ref_clock_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 16, phase-accumulator and frequency-word width.
REQ-002 SHALL have parameter DEFAULT_FREQ, default 16'h1000, frequency word loaded at reset.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port cfgValid  input  1  configuration request.
REQ-006 SHALL have port cfgReady  output  1  block can accept a configuration.
REQ-007 SHALL have port cfgFreq  input  ACC_W  new frequency word.
REQ-008 SHALL have port cfgPhase  input  ACC_W  phase offset added to the accumulator on accept.
REQ-009 SHALL have port sweepEn  input  1  enable linear frequency sweep.
REQ-010 SHALL have port sweepDelta  input  8  frequency increment per accumulator wrap, unsigned.
REQ-011 SHALL have port sweepLimit  input  ACC_W  sweep ceiling, inclusive.
REQ-012 SHALL have port refOut  output  1  generated reference square wave; drives the DPLL base clock input.
REQ-013 SHALL have port refEdge  output  1  one-cycle pulse on each rising edge of refOut.
REQ-014 SHALL have port curFreq  output  ACC_W  frequency word currently applied.

Function
REQ-015 SHALL update the accumulator every cycle: acc <= acc + curFreq, modulo 2^ACC_W; wrap = carry out of that add.
REQ-016 SHALL register refOut as acc[ACC_W-1], giving output frequency f_clk*curFreq/2^ACC_W.
REQ-017 SHALL assert refEdge for exactly one cycle, in the same cycle refOut goes 0->1.
REQ-018 SHALL implement FSM states IDLE and WAIT_WRAP; cfgReady = 1 only in IDLE.
REQ-019 SHALL accept a configuration when cfgValid and cfgReady are both 1 (handshake cycle).
REQ-020 SHALL latch cfgFreq into a pending register in the handshake cycle and move to WAIT_WRAP.
REQ-021 SHALL add cfgPhase to the accumulator in the handshake cycle: acc <= acc + curFreq + cfgPhase, modulo 2^ACC_W. A wrap caused by the phase add SHALL NOT count as a wrap.
REQ-022 SHALL, in WAIT_WRAP, copy the pending frequency to curFreq in the cycle after the next wrap, then return to IDLE. Frequency changes are phase-continuous.
REQ-023 SHALL, in WAIT_WRAP with curFreq = 0, apply the pending frequency on the next cycle without waiting for a wrap (no deadlock).
REQ-024 SHALL ignore cfgValid while in WAIT_WRAP; inputs are not sampled.
REQ-025 SHALL, when sweepEn = 1 and the state is IDLE, on each wrap set curFreq <= min(curFreq + sweepDelta, sweepLimit), evaluated at ACC_W+1 bits (no wrap-around).
REQ-026 SHALL leave curFreq unchanged when curFreq >= sweepLimit or sweepDelta = 0; the sweep never decreases the frequency.
REQ-027 SHALL give a handshake priority over a sweep step in the same cycle; the sweep resumes from the newly applied frequency.
REQ-028 SHALL hold acc and refOut constant when curFreq = 0; refEdge stays 0.

Reset
REQ-029 SHALL, when reset = 0 at a clock edge, set acc = 0, curFreq = DEFAULT_FREQ, refOut = 0, refEdge = 0, state = IDLE and pending register = 0.
REQ-030 SHALL drive cfgReady = 0 while reset is low and 1 from the first cycle after reset is released.
REQ-031 SHALL let a reset asserted in WAIT_WRAP discard the pending frequency.

Verification
REQ-032 SHALL have a test for default frequency: release reset, run 64 cycles -> refOut period 16 cycles, 50% duty, refEdge every 16 cycles, first refEdge at cycle 8.
REQ-033 SHALL have a test for frequency change: handshake cfgFreq = 16'h2000, cfgPhase = 0 -> cfgReady low until the next wrap; curFreq = 16'h2000 the cycle after the wrap; refOut period 8 cycles; no runt pulse.
REQ-034 SHALL have a test for phase step: in steady state at 16'h1000, handshake cfgFreq = 16'h1000, cfgPhase = 16'h4000 -> next refEdge 4 cycles earlier than unperturbed; later period 16 cycles.
REQ-035 SHALL have a test for sweep saturation: sweepEn = 1, sweepDelta = 8'h80, sweepLimit = 16'h1200 -> curFreq 16'h1080, then 16'h1100, 16'h1180, 16'h1200 on successive wraps, then stays at 16'h1200.
REQ-036 SHALL have a test for zero frequency and reset mid-update: cfgFreq = 0 applied -> refOut frozen; then handshake cfgFreq = 16'h1000 -> applied the next cycle; separately, reset in WAIT_WRAP -> curFreq = DEFAULT_FREQ, cfgReady = 1 one cycle after release.

Source files
------------

// File: rtl/ref_clock_gen.sv
// ref_clock_gen: phase-accumulator reference clock with handshaked retune and linear sweep
module ref_clock_gen #(
    parameter int               ACC_W        = 16,
    parameter logic [ACC_W-1:0] DEFAULT_FREQ = 16'h1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfgValid,
    output logic             cfgReady,
    input  logic [ACC_W-1:0] cfgFreq,
    input  logic [ACC_W-1:0] cfgPhase,
    input  logic             sweepEn,
    input  logic [7:0]       sweepDelta,
    input  logic [ACC_W-1:0] sweepLimit,
    output logic             refOut,
    output logic             refEdge,
    output logic [ACC_W-1:0] curFreq
);
    typedef enum logic {IDLE, WAIT_WRAP} state_t;
    state_t state, stateNext;
    logic [ACC_W-1:0] acc, accNext, pending, sweepFreq;
    logic [ACC_W:0]   sum, sweepSum;
    logic             wrap, accept, applyPend, doSweep;

    // Only the carry of acc + curFreq is a wrap; the phase offset is added after it
    assign sum       = {1'b0, acc} + {1'b0, curFreq};
    assign wrap      = sum[ACC_W];
    assign accept    = cfgValid & cfgReady;
    assign accNext   = sum[ACC_W-1:0] + (accept ? cfgPhase : '0);
    assign applyPend = (state == WAIT_WRAP) && (wrap || curFreq == '0);
    assign sweepSum  = {1'b0, curFreq} + (ACC_W+1)'(sweepDelta);
    assign sweepFreq = (sweepSum > {1'b0, sweepLimit}) ? sweepLimit : sweepSum[ACC_W-1:0];
    assign doSweep   = (state == IDLE) && !accept && sweepEn && wrap &&
                       (curFreq < sweepLimit) && (sweepDelta != 8'd0);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= stateNext;
    end

    // Next state: a request parks us until the retune lands on a wrap boundary
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      stateNext = accept    ? WAIT_WRAP : IDLE;
            WAIT_WRAP: stateNext = applyPend ? IDLE      : WAIT_WRAP;
            default:   stateNext = IDLE;
        endcase
    end

    // Ready only when idle and out of reset
    always_comb begin
        cfgReady = (state == IDLE) && reset;
    end

    // Accumulator, square-wave output, edge pulse and frequency word
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc     <= '0;
            curFreq <= DEFAULT_FREQ;
            refOut  <= 1'b0;
            refEdge <= 1'b0;
            pending <= '0;
        end else begin
            acc     <= accNext;
            refOut  <= accNext[ACC_W-1];
            refEdge <= accNext[ACC_W-1] & ~refOut;
            if (accept) pending <= cfgFreq;
            curFreq <= applyPend ? pending : doSweep ? sweepFreq : curFreq;
        end
    end
endmodule

// File: tb/tb_ref_clock_gen.sv
// tb_ref_clock_gen: directed checks of ref_clock_gen against hand-computed values
module tb_ref_clock_gen;
    logic        clk = 1'b0, reset = 1'b0, cfgValid = 1'b0, sweepEn = 1'b0;
    logic        cfgReady, refOut, refEdge;
    logic [15:0] cfgFreq = '0, cfgPhase = '0, sweepLimit = '0, curFreq, prev, hold;
    logic [7:0]  sweepDelta = '0;
    logic [15:0] seq [4];
    int          tests = 0, fails = 0;
    int          n, bad, edges, highs, first, changes;

    ref_clock_gen dut (
        .clk(clk), .reset(reset), .cfgValid(cfgValid), .cfgReady(cfgReady),
        .cfgFreq(cfgFreq), .cfgPhase(cfgPhase), .sweepEn(sweepEn),
        .sweepDelta(sweepDelta), .sweepLimit(sweepLimit), .refOut(refOut),
        .refEdge(refEdge), .curFreq(curFreq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic handshake(input logic [15:0] f, input logic [15:0] p);
        cfgFreq  = f;
        cfgPhase = p;
        cfgValid = 1'b1;
        tick();
        cfgValid = 1'b0;
    endtask

    task automatic waitReady();
        n = 0;
        while (!cfgReady && n < 100) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // reset state
        tick();
        tick();
        chk("rst_curFreq", 32'(curFreq), 32'h1000);
        chk("rst_refOut", 32'(refOut), 32'd0);
        chk("rst_refEdge", 32'(refEdge), 32'd0);
        chk("rst_cfgReady", 32'(cfgReady), 32'd0);
        reset = 1'b1;
        #1;
        chk("release_cfgReady", 32'(cfgReady), 32'd1);

        // default frequency: period 16, first edge at cycle 8
        first = 0; edges = 0; highs = 0; bad = 0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (refEdge && first == 0) first = k;
            edges += int'(refEdge);
            highs += int'(refOut);
            if (refOut !== (k % 16 >= 8) || refEdge !== (k % 16 == 8)) bad++;
        end
        chk("def_first_edge", 32'(first), 32'd8);
        chk("def_edge_count", 32'(edges), 32'd4);
        chk("def_high_cycles", 32'(highs), 32'd32);
        chk("def_pattern", 32'(bad), 32'd0);

        // frequency change to 0x2000, applied after the next wrap
        handshake(16'h2000, 16'h0000);
        chk("chg_ready_low", 32'(cfgReady), 32'd0);
        chk("chg_old_freq", 32'(curFreq), 32'h1000);
        n = 0; bad = 0;
        while (!cfgReady && n < 40) begin
            tick();
            n++;
            if (!cfgReady && refOut !== (n >= 7)) bad++;
        end
        chk("chg_wait_cycles", 32'(n), 32'd15);
        chk("chg_new_freq", 32'(curFreq), 32'h2000);
        chk("chg_wait_refOut", 32'(bad), 32'd0);
        chk("chg_refOut_at_apply", 32'(refOut), 32'd0);
        bad = 0; edges = 0;
        for (int m = 1; m <= 32; m++) begin
            tick();
            edges += int'(refEdge);
            if (refOut !== (m % 8 >= 4) || refEdge !== (m % 8 == 4)) bad++;
        end
        chk("chg_pattern", 32'(bad), 32'd0);
        chk("chg_edge_count", 32'(edges), 32'd4);

        // back to 0x1000, accumulator ends at 0
        handshake(16'h1000, 16'h0000);
        waitReady();
        chk("restore_freq", 32'(curFreq), 32'h1000);

        // phase step of 0x4000: edge arrives after 4 cycles instead of 8
        handshake(16'h1000, 16'h4000);
        n = 1;
        while (!refEdge && n < 40) begin
            tick();
            n++;
        end
        chk("phase_first_edge", 32'(n), 32'd4);
        tick();
        n = 1;
        while (!refEdge && n < 40) begin
            tick();
            n++;
        end
        chk("phase_period", 32'(n), 32'd16);
        chk("phase_freq", 32'(curFreq), 32'h1000);

        // sweep to a 0x1200 ceiling in 0x80 steps
        sweepEn = 1'b1; sweepDelta = 8'h80; sweepLimit = 16'h1200;
        prev = curFreq; changes = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            if (curFreq !== prev) begin
                if (changes < 4) seq[changes] = curFreq;
                changes++;
                prev = curFreq;
            end
        end
        chk("sweep_step1", 32'(seq[0]), 32'h1080);
        chk("sweep_step2", 32'(seq[1]), 32'h1100);
        chk("sweep_step3", 32'(seq[2]), 32'h1180);
        chk("sweep_step4", 32'(seq[3]), 32'h1200);
        chk("sweep_changes", 32'(changes), 32'd4);
        chk("sweep_final", 32'(curFreq), 32'h1200);
        sweepEn = 1'b0;

        // zero frequency freezes the output
        handshake(16'h0000, 16'h0000);
        waitReady();
        chk("zero_freq", 32'(curFreq), 32'h0000);
        hold = 16'(refOut); bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (16'(refOut) !== hold || refEdge !== 1'b0) bad++;
        end
        chk("zero_frozen", 32'(bad), 32'd0);
        handshake(16'h1000, 16'h0000);
        chk("zero_wait_freq", 32'(curFreq), 32'h0000);
        chk("zero_wait_ready", 32'(cfgReady), 32'd0);
        tick();
        chk("zero_applied_freq", 32'(curFreq), 32'h1000);
        chk("zero_applied_ready", 32'(cfgReady), 32'd1);

        // reset while waiting discards the pending word
        handshake(16'h3000, 16'h0000);
        chk("rstw_ready_low", 32'(cfgReady), 32'd0);
        reset = 1'b0;
        tick();
        chk("rstw_curFreq", 32'(curFreq), 32'h1000);
        chk("rstw_refOut", 32'(refOut), 32'd0);
        chk("rstw_ready_in_reset", 32'(cfgReady), 32'd0);
        reset = 1'b1;
        #1;
        chk("rstw_ready_release", 32'(cfgReady), 32'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (curFreq !== 16'h1000 || cfgReady !== 1'b1) bad++;
        end
        chk("rstw_discarded", 32'(bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
